// File: rtl/compare_pkg.sv
// Shared definitions for the compare scheduler: branch funct3 codes and
// the result-slot state encoding.
package compare_pkg;

    localparam logic [2:0] F_EQ  = 3'b000;
    localparam logic [2:0] F_NE  = 3'b001;
    localparam logic [2:0] F_LT  = 3'b100;
    localparam logic [2:0] F_GE  = 3'b101;
    localparam logic [2:0] F_LTU = 3'b110;
    localparam logic [2:0] F_GEU = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/comparator_eq.sv
// Zero detector on a subtraction result: eq is high when the difference is zero.
module comparator_eq #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] s,
    output logic             eq
);

    assign eq = (s == '0);

endmodule

// File: rtl/comparator_scheduler.sv
// Two-port round-robin scheduler around one shared subtract-and-compare
// datapath, returning RISC-V branch conditions through a registered response slot.
module comparator_scheduler
    import compare_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_funct,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp0_taken,
    output logic             resp0_err,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_funct,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic             resp1_taken,
    output logic             resp1_err
);

    state_e r_state;
    logic   r_own;
    logic   r_prio;
    logic   r_taken;
    logic   r_err;

    logic             w_hold;
    logic             w_own_ready;
    logic             w_free;
    logic             w_grant;
    logic             w_accept;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [2:0]       w_funct;
    logic [WIDTH:0]   w_diff;
    logic             w_eq;
    logic             w_lt;
    logic             w_ltu;
    logic             w_taken;
    logic             w_err;

    assign w_hold      = (r_state == ST_HOLD);
    assign w_own_ready = r_own ? resp1_ready : resp0_ready;
    // The slot frees in the same cycle its owner consumes the result.
    assign w_free      = ~w_hold | w_own_ready;

    assign w_grant  = (req0_valid & req1_valid) ? r_prio : req1_valid;
    // Readies are masked during reset so nothing is accepted while rst_n is low.
    assign w_accept = rst_n & w_free & (req0_valid | req1_valid);

    assign req0_ready = w_accept & ~w_grant;
    assign req1_ready = w_accept & w_grant;

    assign w_a     = w_grant ? req1_a : req0_a;
    assign w_b     = w_grant ? req1_b : req0_b;
    assign w_funct = w_grant ? req1_funct : req0_funct;

    assign w_diff = {1'b0, w_a} - {1'b0, w_b};

    comparator_eq #(
        .WIDTH (WIDTH)
    ) u_eq (
        .s  (w_diff[WIDTH-1:0]),
        .eq (w_eq)
    );

    // With differing signs the subtraction can overflow, so the sign of a decides.
    assign w_lt  = (w_a[WIDTH-1] != w_b[WIDTH-1]) ? w_a[WIDTH-1] : w_diff[WIDTH-1];
    assign w_ltu = w_diff[WIDTH];

    always_comb begin
        w_taken = 1'b0;
        w_err   = 1'b0;
        case (w_funct)
            F_EQ:    w_taken = w_eq;
            F_NE:    w_taken = ~w_eq;
            F_LT:    w_taken = w_lt;
            F_GE:    w_taken = ~w_lt;
            F_LTU:   w_taken = w_ltu;
            F_GEU:   w_taken = ~w_ltu;
            default: w_err   = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_own   <= 1'b0;
            r_prio  <= 1'b0;
            r_taken <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_own_ready && !w_accept) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_accept) begin
                r_own   <= w_grant;
                r_prio  <= ~w_grant;
                r_taken <= w_taken;
                r_err   <= w_err;
            end
        end
    end

    assign resp0_valid = w_hold & ~r_own;
    assign resp1_valid = w_hold & r_own;
    assign resp0_taken = resp0_valid & r_taken;
    assign resp0_err   = resp0_valid & r_err;
    assign resp1_taken = resp1_valid & r_taken;
    assign resp1_err   = resp1_valid & r_err;

endmodule

// File: tb/tb_comparator_scheduler.sv
// Directed bench for comparator_scheduler: reset, branch conditions, arbitration,
// back-pressure and reset while a result is held.
module tb_comparator_scheduler;

    localparam int unsigned WIDTH = 64;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_taken, resp0_err;
    logic             req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_taken, resp1_err;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]       req0_funct, req1_funct;

    int checks = 0;
    int errors = 0;

    comparator_scheduler #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_funct  (req0_funct),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp0_taken (resp0_taken),
        .resp0_err   (resp0_err),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_funct  (req1_funct),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp1_taken (resp1_taken),
        .resp1_err   (resp1_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Step past the next rising edge; outputs are then sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single port-0 transaction on an idle slot with port 1 quiet.
    task automatic p0_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] f, input logic exp_taken, input logic exp_err);
        req0_valid  = 1'b1;
        req0_a      = a;
        req0_b      = b;
        req0_funct  = f;
        resp0_ready = 1'b0;
        #1;
        chk({tag, "_rdy"}, req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        #1;
        chk({tag, "_vld"}, resp0_valid, 1'b1);
        chk({tag, "_taken"}, resp0_taken, exp_taken);
        chk({tag, "_err"}, resp0_err, exp_err);
        resp0_ready = 1'b1;
        tick();
        resp0_ready = 1'b0;
        #1;
        chk({tag, "_drain"}, resp0_valid, 1'b0);
    endtask

    initial begin
        logic g;
        logic exp_t;

        rst_n       = 1'b0;
        req0_valid  = 1'b1;
        req1_valid  = 1'b1;
        req0_a      = '0;
        req0_b      = '0;
        req1_a      = '0;
        req1_b      = '0;
        req0_funct  = 3'b000;
        req1_funct  = 3'b000;
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;

        // Reset with both ports requesting
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_rdy0", req0_ready, 1'b0);
            chk("rst_rdy1", req1_ready, 1'b0);
            chk("rst_vld0", resp0_valid, 1'b0);
            chk("rst_vld1", resp1_valid, 1'b0);
            chk("rst_tkn0", resp0_taken, 1'b0);
            chk("rst_err1", resp1_err, 1'b0);
        end

        // Port 0 wins first; port 1 waits behind the held result
        rst_n      = 1'b1;
        req0_a     = 64'h5;
        req0_b     = 64'h5;
        req0_funct = 3'b000;
        req1_a     = 64'h1;
        req1_b     = 64'h2;
        req1_funct = 3'b100;
        #1;
        chk("first_rdy0", req0_ready, 1'b1);
        chk("first_rdy1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("beq_vld", resp0_valid, 1'b1);
        chk("beq_taken", resp0_taken, 1'b1);
        chk("beq_err", resp0_err, 1'b0);
        chk("beq_vld1", resp1_valid, 1'b0);
        chk("wait_rdy1", req1_ready, 1'b0);
        resp0_ready = 1'b1;
        #1;
        chk("free_rdy1", req1_ready, 1'b1);
        tick();
        resp0_ready = 1'b0;
        req1_valid  = 1'b0;
        #1;
        chk("p1_vld", resp1_valid, 1'b1);
        chk("p1_taken", resp1_taken, 1'b1);
        chk("p1_vld0", resp0_valid, 1'b0);
        chk("p1_tkn0", resp0_taken, 1'b0);
        resp1_ready = 1'b1;
        tick();
        resp1_ready = 1'b0;
        #1;
        chk("p1_drain", resp1_valid, 1'b0);

        // Condition decode
        p0_op("beq_ne",   64'h5, 64'h6, 3'b000, 1'b0, 1'b0);
        p0_op("bne",      64'h5, 64'h6, 3'b001, 1'b1, 1'b0);
        p0_op("blt_neg",  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b100, 1'b1, 1'b0);
        p0_op("bltu_neg", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b110, 1'b0, 1'b0);
        p0_op("bgeu_neg", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b111, 1'b1, 1'b0);
        p0_op("bge_neg",  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b101, 1'b0, 1'b0);
        p0_op("ill010",   64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b010, 1'b0, 1'b1);
        p0_op("ill011",   64'h5, 64'h5, 3'b011, 1'b0, 1'b1);
        p0_op("blt_same", 64'h3, 64'h7, 3'b100, 1'b1, 1'b0);
        p0_op("bge_eq",   64'h7, 64'h7, 3'b101, 1'b1, 1'b0);
        p0_op("blt_ovf",  64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 3'b100, 1'b1, 1'b0);
        p0_op("bltu_ovf", 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 3'b110, 1'b0, 1'b0);
        p0_op("bgeu_eq0", 64'h0, 64'h0, 3'b111, 1'b1, 1'b0);

        // Contention: last accept was port 0, so port 1 is favoured next
        req0_valid  = 1'b1;
        req0_a      = 64'h1;
        req0_b      = 64'h1;
        req0_funct  = 3'b000;
        req1_valid  = 1'b1;
        req1_a      = 64'h1;
        req1_b      = 64'h2;
        req1_funct  = 3'b000;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        g = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_rdy0", req0_ready, ~g);
            chk("rr_rdy1", req1_ready, g);
            tick();
            exp_t = ~g;
            chk("rr_vld0", resp0_valid, ~g);
            chk("rr_vld1", resp1_valid, g);
            chk("rr_taken", g ? resp1_taken : resp0_taken, exp_t);
            g = ~g;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        #1;
        chk("rr_drain0", resp0_valid, 1'b0);
        chk("rr_drain1", resp1_valid, 1'b0);

        // Back-pressure: port 0 holds the slot while port 1 waits
        req0_valid = 1'b1;
        req0_a     = 64'h5;
        req0_b     = 64'h5;
        req0_funct = 3'b111;
        #1;
        chk("bp_rdy0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_a     = 64'h2;
        req1_b     = 64'h1;
        req1_funct = 3'b101;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rdy1", req1_ready, 1'b0);
            chk("bp_vld0", resp0_valid, 1'b1);
            chk("bp_tkn0", resp0_taken, 1'b1);
            chk("bp_err0", resp0_err, 1'b0);
            tick();
        end
        resp0_ready = 1'b1;
        #1;
        chk("bp_rel_rdy1", req1_ready, 1'b1);
        tick();
        resp0_ready = 1'b0;
        req1_valid  = 1'b0;
        #1;
        chk("bp_vld1", resp1_valid, 1'b1);
        chk("bp_tkn1", resp1_taken, 1'b1);
        chk("bp_vld0_off", resp0_valid, 1'b0);

        // Reset while port 1's result is held
        rst_n = 1'b0;
        tick();
        chk("rh_vld1", resp1_valid, 1'b0);
        chk("rh_tkn1", resp1_taken, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("rh_post_vld1", resp1_valid, 1'b0);
        chk("rh_post_vld0", resp0_valid, 1'b0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rh_prio_rdy0", req0_ready, 1'b1);
        chk("rh_prio_rdy1", req1_ready, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        chk("rh_idle_vld0", resp0_valid, 1'b0);
        chk("rh_idle_vld1", resp1_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comparator_scheduler.md
# comparator_scheduler

Shares one WIDTH-bit subtract-and-compare datapath between two requesters: the integer branch unit (port 0) and the set-less-than/FP-compare path (port 1). It arbitrates round-robin, and computes the RISC-V branch condition selected by funct3 from the difference `s = a - b`. Zero detection uses the existing `comparator_eq`. Results come back through a single registered response slot with a valid/ready handshake. The block sits between the decode/issue stage and the shared ALU compare resource.

## Interface
- `WIDTH`, default 64, operand width in bits.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req0_valid` in 1: port 0 request present.
- `req0_ready` out 1: port 0 request accepted this cycle.
- `req0_a`, `req0_b` in WIDTH: port 0 operands.
- `req0_funct` in 3: port 0 compare op (RISC-V branch funct3).
- `resp0_valid` out 1: port 0 result pending.
- `resp0_ready` in 1: port 0 consumes its result.
- `resp0_taken` out 1: port 0 condition result.
- `resp0_err` out 1: port 0 funct was illegal.
- `req1_*`, `resp1_*`: identical set for port 1.

## Operation
- funct3 encoding:
  - 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - 010 and 011 are illegal: taken=0, err=1.
- Arithmetic:
  - `s = {1'b0,a} - {1'b0,b}`, computed at WIDTH+1 bits.
  - `borrow = s[WIDTH]`.
  - `eq` comes from `comparator_eq` applied to `s[WIDTH-1:0]`.
  - `lt`: if `a[MSB] != b[MSB]`, then `lt = a[MSB]`; otherwise `lt = s[WIDTH-1]`.
  - `ltu = borrow`.
  - NE, GE and GEU are the inversions of EQ, LT and LTU.
- Result slot FSM, two states:
  - IDLE: no result held.
  - HOLD: result held for owner `own`, which is 0 or 1.
- Transitions:
  - IDLE to HOLD on any accept.
  - HOLD to IDLE when `resp_own_ready` is high and there is no new accept.
  - HOLD to HOLD when `resp_own_ready` is high and a new accept happens in the same cycle. The slot is reloaded and `own` is updated.
- Slot free condition: `free = (state==IDLE) | (resp_own_valid & resp_own_ready)`.
- Arbitration:
  - Pointer `prio` marks the favoured port.
  - If both ports are valid, grant `prio`.
  - If only one is valid, grant it.
  - `reqN_ready = free & grant==N`. At most one ready per cycle.
  - `reqN_ready` depends combinationally on `resp_own_ready`.
- Pointer update: on an accept from port N, `prio <= ~N`. With no accept, `prio` holds.
- Response outputs:
  - `respN_valid = (state==HOLD) & (own==N)`.
  - `taken`/`err` are driven on the owner's port only; the other port drives 0.
- The requester must hold operands stable while `valid & ~ready`. The block never drops a pending result.

## Timing
- Reset values while `rst_n`=0 at an edge:
  - state=IDLE, `prio`=0, `own`=0.
  - All `*_ready`, `*_valid`, `*_taken` and `*_err` are 0.
- Reset mid-HOLD discards the pending result. No response appears afterwards.
- Latency: an accept at edge k gives `resp_valid` high after edge k, with result fields stable in that cycle.
- Throughput: one result per cycle when the owner asserts `resp_ready` continuously. Back-to-back accepts are legal through the HOLD-to-HOLD reload.
- Result fields are registered. There is no combinational path from the operands to the response outputs.
- Simultaneous events:
  - A port whose own result is pending may still be granted if it asserts `resp_ready` in the same cycle.
  - A port that is not the owner must wait for the slot to free.

## Structure
- Shared package, `compare_pkg`:
  - funct3 localparams `F_EQ`, `F_NE`, `F_LT`, `F_GE`, `F_LTU`, `F_GEU`.
  - FSM state encodings `ST_IDLE`, `ST_HOLD`.
- Sub-module: existing `comparator_eq` (ports `s`, `eq`), instantiated once on the shared difference. No other sub-modules.
- Operand mux, subtractor, condition logic, arbiter and slot are all in `comparator_scheduler`.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with both ports valid -> all readies and valids stay 0. After release, `prio`=0, so port 0 is granted first.
- **Port 0 BEQ:** a=b=64'h5 -> `req0_ready` for 1 cycle, then `resp0_valid`=1, taken=1, err=0. A second request with a=5, b=6 -> taken=0.
- **Signed vs unsigned:** a=64'hFFFF_FFFF_FFFF_FFFF, b=1.
  - BLT -> taken=1.
  - BLTU -> taken=0.
  - BGEU -> taken=1.
  - funct=010 -> taken=0, err=1.
- **Contention:** both ports valid continuously with `resp_ready`=1 -> grants alternate 0,1,0,1. A result appears every cycle on the alternating port.
- **Back-pressure:**
  - Port 0 result pending with `resp0_ready`=0 for 3 cycles while port 1 is valid -> `req1_ready` stays 0 and resp0 fields stay stable.
  - On `resp0_ready`=1, port 1 is accepted in the same cycle.
- **Reset mid-HOLD:** drive `rst_n`=0 with resp1 pending -> the next cycle has `resp1_valid`=0, and no stale result appears after release.
